// File: rtl/smc_regbank_pkg.sv
// Shared register map, ID default and access classes for the SMC register bank slave.
package smc_regbank_pkg;

  localparam int unsigned REG_IDX_W = 8;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ID         = 8'd0;
  localparam reg_idx_t REG_SCRATCH    = 8'd1;
  localparam reg_idx_t REG_LED        = 8'd2;
  localparam reg_idx_t REG_IRQ_STATUS = 8'd3;
  localparam reg_idx_t REG_IRQ_MASK   = 8'd4;
  localparam reg_idx_t REG_IRQ_FORCE  = 8'd5;
  localparam reg_idx_t REG_CNT_LO     = 8'd6;
  localparam reg_idx_t REG_CNT_HI     = 8'd7;
  localparam reg_idx_t REG_ERR        = 8'd8;

  localparam logic [15:0] ID_DEFAULT = 16'hA55A;

  typedef enum logic [2:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C,
    ACC_WO,
    ACC_NONE
  } acc_e;

  function automatic acc_e reg_access(input reg_idx_t idx);
    acc_e acc;
    acc = ACC_NONE;
    case (idx)
      REG_ID, REG_CNT_LO, REG_CNT_HI, REG_ERR: acc = ACC_RO;
      REG_SCRATCH, REG_LED, REG_IRQ_MASK:      acc = ACC_RW;
      REG_IRQ_STATUS:                          acc = ACC_W1C;
      REG_IRQ_FORCE:                           acc = ACC_WO;
      default:                                 acc = ACC_NONE;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/smc_sync.sv
// N-stage flop synchroniser with a configurable per-bit reset value.
module smc_sync #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/smc_regbank_slave.sv
// SMC bus slave: decoded register bank, edge-triggered interrupt controller,
// free-running counter with snapshot-on-read, and saturating error counter.
module smc_regbank_slave
  import smc_regbank_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned ADDR_LSB    = 1,
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IRQ_W       = 4,
  parameter int unsigned LED_W       = 5,
  parameter logic [15:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic              cs_i,
  input  logic [IRQ_W-1:0]  irq_i,
  output logic              irq_o,
  output logic [LED_W-1:0]  leds_o
);

  logic              rd_act, wr_act;
  logic [1:0]        strb_s, strb_q;
  logic              rd_ev, wr_ev;
  logic [IRQ_W-1:0]  irq_s, irq_q, irq_rise;
  reg_idx_t          ev_sel, rd_sel;
  acc_e              ev_acc;
  logic              err_inc;
  logic              rd_pend;
  logic [REG_AW-1:0] rd_idx;
  logic [DATA_W-1:0] rd_data, scratch, err_cnt, snap;
  logic [LED_W-1:0]  leds;
  logic [IRQ_W-1:0]  status, status_nx, mask;
  logic [2*DATA_W-1:0] cnt;
  logic              unused_addr;

  assign rd_act    = ~cs_i & ~read_i;
  assign wr_act    = ~cs_i & ~write_i;
  assign data_oe_o = rd_act;
  assign leds_o    = leds;
  assign unused_addr = ^addr_i;

  // Strobe chain and edge flop reset to "active" so a strobe held across reset
  // must be seen inactive before it can raise an event.
  smc_sync #(.WIDTH(2), .STAGES(SYNC_STAGES), .RESET_VAL(2'b11)) u_strb_sync (
    .clk(clk_i), .rst_n(reset_i), .d({wr_act, rd_act}), .q(strb_s)
  );

  smc_sync #(.WIDTH(IRQ_W), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_irq_sync (
    .clk(clk_i), .rst_n(reset_i), .d(irq_i), .q(irq_s)
  );

  assign rd_ev    = strb_s[0] & ~strb_q[0];
  assign wr_ev    = strb_s[1] & ~strb_q[1] & ~rd_ev;
  assign irq_rise = irq_s & ~irq_q;

  assign ev_sel  = REG_IDX_W'(addr_i[ADDR_LSB +: REG_AW]);
  assign rd_sel  = REG_IDX_W'(rd_idx);
  assign ev_acc  = reg_access(ev_sel);
  assign err_inc = (rd_ev && ev_acc == ACC_NONE) ||
                   (wr_ev && (ev_acc == ACC_NONE || ev_acc == ACC_RO));

  // Sets are applied after the W1C clear so a coinciding set wins.
  always_comb begin
    status_nx = status;
    if (wr_ev && ev_sel == REG_IRQ_STATUS) status_nx = status_nx & ~data_i[IRQ_W-1:0];
    if (wr_ev && ev_sel == REG_IRQ_FORCE)  status_nx = status_nx | data_i[IRQ_W-1:0];
    status_nx = status_nx | irq_rise;
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      REG_ID:         rd_data = DATA_W'(ID_VALUE);
      REG_SCRATCH:    rd_data = scratch;
      REG_LED:        rd_data = DATA_W'(leds);
      REG_IRQ_STATUS: rd_data = DATA_W'(status);
      REG_IRQ_MASK:   rd_data = DATA_W'(mask);
      REG_CNT_LO:     rd_data = cnt[DATA_W-1:0];
      REG_CNT_HI:     rd_data = snap;
      REG_ERR:        rd_data = err_cnt;
      default:        rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      strb_q  <= 2'b11;
      irq_q   <= '0;
      rd_pend <= 1'b0;
      rd_idx  <= '0;
      data_o  <= '0;
      scratch <= '0;
      leds    <= '0;
      status  <= '0;
      mask    <= '0;
      cnt     <= '0;
      snap    <= '0;
      err_cnt <= '0;
      irq_o   <= 1'b1;
    end else begin
      strb_q  <= strb_s;
      irq_q   <= irq_s;
      cnt     <= cnt + 1'b1;
      status  <= status_nx;
      irq_o   <= ~|(status & mask);
      rd_pend <= rd_ev;
      if (rd_ev) rd_idx <= addr_i[ADDR_LSB +: REG_AW];
      if (rd_pend) begin
        data_o <= rd_data;
        if (rd_sel == REG_CNT_LO) snap <= cnt[2*DATA_W-1:DATA_W];
      end
      if (wr_ev) begin
        case (ev_sel)
          REG_SCRATCH:  scratch <= data_i;
          REG_LED:      leds    <= data_i[LED_W-1:0];
          REG_IRQ_MASK: mask    <= data_i[IRQ_W-1:0];
          default: ;
        endcase
      end
      if (err_inc && ~&err_cnt) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_smc_regbank_slave.sv
// Randomised and directed bench for smc_regbank_slave against a register-level reference model.
module tb_smc_regbank_slave;

  localparam int SYNC = 2;
  localparam int LSB  = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in, data_out;
  logic        data_oe;
  logic [24:0] addr;
  logic        nrd, nwe, ncs;
  logic [3:0]  irq;
  logic        irq_n;
  logic [4:0]  leds;

  logic [31:0] cyc;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [15:0] m_scratch, m_err, m_snap;
  logic [4:0]  m_led;
  logic [3:0]  m_status, m_mask;
  logic [24:0] ra;

  smc_regbank_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk_i(clk), .reset_i(rst_n), .data_i(data_in), .data_o(data_out),
    .data_oe_o(data_oe), .addr_i(addr), .read_i(nrd), .write_i(nwe),
    .cs_i(ncs), .irq_i(irq), .irq_o(irq_n), .leds_o(leds)
  );

  always #5 clk = ~clk;

  // Free-running cycle count since reset release: the value the DUT counter should hold.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 1;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task m_reset();
    m_scratch = '0; m_err = '0; m_snap = '0; m_led = '0; m_status = '0; m_mask = '0;
  endtask

  task m_err_bump();
    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
  endtask

  task automatic bus_write(input logic [24:0] a, input logic [15:0] d, input logic [3:0] irq_set);
    int idx;
    @(negedge clk);
    addr = a; data_in = d; ncs = 1'b0; nwe = 1'b0; irq = irq_set;
    #1 check("oe_during_write", data_oe, 1'b0);
    repeat (SYNC + 2) @(negedge clk);
    ncs = 1'b1; nwe = 1'b1; irq = '0;
    idx = int'(a[LSB +: 4]);
    case (idx)
      1: m_scratch = d;
      2: m_led = d[4:0];
      3: m_status = m_status & ~d[3:0];
      4: m_mask = d[3:0];
      5: m_status = m_status | d[3:0];
      default: m_err_bump();
    endcase
    m_status = m_status | irq_set;
    repeat (4) @(negedge clk);
    check("irq_o", irq_n, !(|(m_status & m_mask)));
    check("leds", leds, m_led);
  endtask

  task automatic bus_read(input logic [24:0] a, input string tag);
    logic [31:0] n0, c;
    logic [15:0] exp;
    int idx;
    @(negedge clk);
    addr = a; ncs = 1'b0; nrd = 1'b0; n0 = cyc;
    #1 check("oe_during_read", data_oe, 1'b1);
    idx = int'(a[LSB +: 4]);
    c = n0 + SYNC + 1;
    case (idx)
      0: exp = 16'hA55A;
      1: exp = m_scratch;
      2: exp = {11'b0, m_led};
      3: exp = {12'b0, m_status};
      4: exp = {12'b0, m_mask};
      5: exp = 16'h0;
      6: begin exp = c[15:0]; m_snap = c[31:16]; end
      7: exp = m_snap;
      8: exp = m_err;
      default: begin exp = 16'h0; m_err_bump(); end
    endcase
    repeat (SYNC + 2) @(posedge clk);
    #1 check(tag, data_out, exp);
    repeat (3) @(negedge clk);
    ncs = 1'b1; nrd = 1'b1;
    #1 check("oe_after_read", data_oe, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_irq(input logic [3:0] m);
    @(negedge clk);
    irq = m; m_status = m_status | m;
    repeat (SYNC + 3) @(posedge clk);
    #1 check("irq_o_after_edge", irq_n, !(|(m_status & m_mask)));
    @(negedge clk);
    irq = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ncs = 1'b1; nrd = 1'b1; nwe = 1'b1;
    irq = '0; addr = '0; data_in = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_data_o", data_out, 16'h0);
    check("rst_leds", leds, 5'h0);
    check("rst_irq_o", irq_n, 1'b1);
    check("rst_oe", data_oe, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    bus_read(25'h0000000, "rd_id");
    bus_read(25'h0000010, "rd_err_initial");
    bus_write(25'h0000002, 16'h1234, '0);
    bus_read(25'h0001002, "rd_scratch_alias");
    bus_write(25'h0000004, 16'h0015, '0);

    bus_write(25'h0000008, 16'h0005, '0);
    pulse_irq(4'b0001);
    pulse_irq(4'b0010);
    bus_read(25'h0000006, "rd_status_0011");
    bus_write(25'h0000006, 16'h0001, '0);
    bus_read(25'h0000006, "rd_status_0010");
    bus_write(25'h0000006, 16'h0004, 4'b0100);
    bus_read(25'h0000006, "rd_status_set_wins");

    bus_write(25'h0000018, 16'hFFFF, '0);
    bus_write(25'h0000000, 16'h5555, '0);
    bus_read(25'h0000012, "rd_unmapped");
    bus_read(25'h0000010, "rd_err_3");

    // Reset in the middle of a write pulse; the held strobe must not fire after release.
    @(negedge clk);
    addr = 25'h0000002; data_in = 16'hDEAD; ncs = 1'b0; nwe = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_data_o", data_out, 16'h0);
    check("midrst_leds", leds, 5'h0);
    check("midrst_irq_o", irq_n, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (5) @(negedge clk);
    ncs = 1'b1; nwe = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(25'h0000002, "rd_scratch_after_rst");
    bus_read(25'h0000010, "rd_err_after_rst");
    bus_write(25'h0000002, 16'hBEEF, '0);
    bus_read(25'h0000002, "rd_scratch_next_pulse");

    for (int i = 0; i < 60; i++) begin
      ra = 25'($urandom);
      if ($urandom_range(0, 1) == 1) bus_write(ra, 16'($urandom), '0);
      else bus_read(ra, "rd_rand");
    end

    for (int i = 0; i < 70000 && cyc < 32'h0000FFFB; i++) @(negedge clk);
    bus_read(25'h000000C, "rd_cnt_lo_ffff");
    bus_read(25'h000000E, "rd_cnt_hi_snap0");
    bus_read(25'h000000C, "rd_cnt_lo_wrapped");
    bus_read(25'h000000E, "rd_cnt_hi_snap1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
